// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared encodings for the pipeline sequencer and hazard logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } seqState_t;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;

endpackage

`default_nettype wire

// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
// Module   : pipeline_sequencer_if
// Brief    : Pipeline-facing bus between the sequencer and the datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if;
  logic [5:0] ifid_opcode;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic       pc_src;
  logic       jump_flag;

  logic       clkEnable;
  logic       pc_write;
  logic       ifid_write;
  logic       inHazard;
  logic       ifid_flush;

  modport master (
    input  ifid_opcode, ifid_rs, ifid_rt, idex_memread, idex_rt, pc_src, jump_flag,
    output clkEnable, pc_write, ifid_write, inHazard, ifid_flush
  );

  modport slave (
    output ifid_opcode, ifid_rs, ifid_rt, idex_memread, idex_rt, pc_src, jump_flag,
    input  clkEnable, pc_write, ifid_write, inHazard, ifid_flush
  );
endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use compare between ID/EX load and IF/ID sources.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_detect (
  input  logic       idexMemRead,
  input  logic [4:0] idexRt,
  input  logic [4:0] ifidRs,
  input  logic [4:0] ifidRt,
  output logic       loadUse
);
  // $zero never carries a real dependency, so a load into r0 cannot stall.
  assign loadUse = idexMemRead && (idexRt != 5'd0) &&
                   ((idexRt == ifidRs) || (idexRt == ifidRt));
endmodule

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Brief    : Run/step/pause sequencer with load-use stall, flush and HALT drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [5:0] OPC_HALT     = pipe_ctrl_pkg::OPC_HALT,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  pipeline_sequencer_if.master bus,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);
  import pipe_ctrl_pkg::*;

  localparam logic [3:0] C_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  seqState_t        r_state, w_nextState;
  logic [3:0]       r_drainCnt, w_drainCntNext;
  logic [CNT_W-1:0] r_cycleCount, r_stallCount;
  logic             w_loadUse, w_redirect, w_enable, w_haltDetect, w_active;

  hazard_detect u_hazardDetect (
    .idexMemRead (bus.idex_memread),
    .idexRt      (bus.idex_rt),
    .ifidRs      (bus.ifid_rs),
    .ifidRt      (bus.ifid_rt),
    .loadUse     (w_loadUse)
  );

  assign w_redirect   = bus.pc_src | bus.jump_flag;
  assign w_active     = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_enable     = w_active || (r_state == S_DRAIN);
  // A HALT shadowed by a taken branch/jump is on the wrong path and is dropped.
  assign w_haltDetect = (bus.ifid_opcode == OPC_HALT) && !w_redirect && w_enable;

  assign bus.clkEnable = w_enable;
  assign halted        = (r_state == S_HALTED);
  assign state         = r_state;
  assign cycle_count   = r_cycleCount;
  assign stall_count   = r_stallCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_drainCnt <= 4'd0;
    end else begin
      r_state    <= w_nextState;
      r_drainCnt <= w_drainCntNext;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_drainCntNext = r_drainCnt;
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    bus.inHazard   = 1'b0;
    bus.ifid_flush = 1'b0;

    // Redirect flush outranks the load-use stall in RUN/STEP.
    if (w_active) begin
      if (w_redirect) begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b1;
      end else if (w_loadUse) begin
        bus.inHazard   = 1'b1;
      end else begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (run_req)       w_nextState = S_RUN;
        else if (step_req) w_nextState = S_STEP;
      end
      S_RUN: begin
        if (w_haltDetect) begin
          w_nextState    = S_DRAIN;
          w_drainCntNext = C_DRAIN_LOAD;
        end else if (halt_req) begin
          w_nextState    = S_IDLE;
        end
      end
      S_STEP: begin
        if (w_haltDetect) begin
          w_nextState    = S_DRAIN;
          w_drainCntNext = C_DRAIN_LOAD;
        end else begin
          w_nextState    = S_IDLE;
        end
      end
      S_DRAIN: begin
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b1;
        if (r_drainCnt == 4'd0) w_nextState    = S_HALTED;
        else                    w_drainCntNext = r_drainCnt - 4'd1;
      end
      S_HALTED: ;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycleCount <= '0;
      r_stallCount <= '0;
    end else begin
      if (w_enable && (r_cycleCount != {CNT_W{1'b1}}))
        r_cycleCount <= r_cycleCount + CNT_W'(1);
      if (bus.inHazard && (r_stallCount != {CNT_W{1'b1}}))
        r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_sequencer
// Brief    : Scoreboard bench with a cycle-level reference model of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipeline_sequencer;
  localparam int DRAIN_CYCLES = 4;

  logic clk = 1'b0;
  logic reset, run_req, step_req, halt_req;
  logic halted, haltedS;
  logic [2:0] state, stateS;
  logic [31:0] cyc, stall;
  logic [3:0] cycS, stallS;

  pipeline_sequencer_if bus ();
  pipeline_sequencer_if busS ();

  assign busS.ifid_opcode  = bus.ifid_opcode;
  assign busS.ifid_rs      = bus.ifid_rs;
  assign busS.ifid_rt      = bus.ifid_rt;
  assign busS.idex_memread = bus.idex_memread;
  assign busS.idex_rt      = bus.idex_rt;
  assign busS.pc_src       = bus.pc_src;
  assign busS.jump_flag    = bus.jump_flag;

  always #5 clk = ~clk;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .OPC_HALT(6'h3f), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .bus(bus), .halted(halted), .state(state), .cycle_count(cyc), .stall_count(stall)
  );

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .OPC_HALT(6'h3f), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .bus(busS), .halted(haltedS), .state(stateS), .cycle_count(cycS), .stall_count(stallS)
  );

  typedef struct {
    logic [8:0] ctl;
    longint     cyc;
    longint     stall;
  } exp_t;

  typedef struct {
    bit rstn, run, step, halt;
    logic [5:0] opc;
    logic [4:0] rs, rt;
    bit mr;
    logic [4:0] irt;
    bit pcs, jmp;
  } stim_t;

  exp_t sbQ[$];
  int tests = 0;
  int fails = 0;

  // Model state: 0 idle, 1 run, 2 step, 3 drain, 4 halted
  int mMode = 0, nMode = 0;
  int mDrainDone = 0, nDrainDone = 0;
  longint mCyc = 0, nCyc = 0, mStall = 0, nStall = 0;

  function automatic stim_t nop();
    stim_t s;
    s.rstn = 1; s.run = 0; s.step = 0; s.halt = 0;
    s.opc = 6'd0; s.rs = 5'd1; s.rt = 5'd2;
    s.mr = 0; s.irt = 5'd0; s.pcs = 0; s.jmp = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit en, br, lu, pcw, ifw, hz, fl, haltSeen;
    @(posedge clk);
    mMode = nMode; mDrainDone = nDrainDone; mCyc = nCyc; mStall = nStall;
    #1;
    reset = s.rstn; run_req = s.run; step_req = s.step; halt_req = s.halt;
    bus.ifid_opcode = s.opc; bus.ifid_rs = s.rs; bus.ifid_rt = s.rt;
    bus.idex_memread = s.mr; bus.idex_rt = s.irt; bus.pc_src = s.pcs; bus.jump_flag = s.jmp;
    if (!s.rstn) begin
      mMode = 0; mDrainDone = 0; mCyc = 0; mStall = 0;
    end
    en = (mMode >= 1 && mMode <= 3);
    br = s.pcs || s.jmp;
    lu = s.mr && (s.irt != 0) && (s.irt == s.rs || s.irt == s.rt);
    {pcw, ifw, hz, fl} = 4'b0000;
    if (mMode == 1 || mMode == 2) begin
      if (br)      {pcw, ifw, hz, fl} = 4'b1101;
      else if (lu) {pcw, ifw, hz, fl} = 4'b0010;
      else         {pcw, ifw, hz, fl} = 4'b1100;
    end else if (mMode == 3) begin
      {pcw, ifw, hz, fl} = 4'b0101;
    end
    haltSeen = (s.opc == 6'h3f) && !br && en;
    e.ctl = {en, pcw, ifw, hz, fl, (mMode == 4), 3'(mMode)};
    e.cyc = mCyc; e.stall = mStall;
    sbQ.push_back(e);

    nMode = mMode; nDrainDone = mDrainDone;
    nCyc = mCyc + (en ? 1 : 0); nStall = mStall + (hz ? 1 : 0);
    if (!s.rstn) begin
      nMode = 0; nDrainDone = 0; nCyc = 0; nStall = 0;
    end else begin
      case (mMode)
        0: if (s.run) nMode = 1; else if (s.step) nMode = 2;
        1: if (haltSeen) begin nMode = 3; nDrainDone = 1; end else if (s.halt) nMode = 0;
        2: if (haltSeen) begin nMode = 3; nDrainDone = 1; end else nMode = 0;
        3: if (mDrainDone >= DRAIN_CYCLES) nMode = 4; else nDrainDone = mDrainDone + 1;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(nop());
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      logic [3:0] eCycS, eStallS;
      e = sbQ.pop_front();
      act = {bus.clkEnable, bus.pc_write, bus.ifid_write, bus.inHazard, bus.ifid_flush, halted, state};
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL ctl t=%0t {en,pcw,ifw,hz,fl,halted,state} act=%b exp=%b", $time, act, e.ctl);
      end
      tests++;
      if (cyc !== 32'(e.cyc) || stall !== 32'(e.stall)) begin
        fails++;
        $display("FAIL counters t=%0t cycle/stall act=%0d/%0d exp=%0d/%0d", $time, cyc, stall, e.cyc, e.stall);
      end
      eCycS   = (e.cyc > 15)   ? 4'd15 : 4'(e.cyc);
      eStallS = (e.stall > 15) ? 4'd15 : 4'(e.stall);
      tests++;
      if (cycS !== eCycS || stallS !== eStallS || stateS !== e.ctl[2:0] || haltedS !== e.ctl[3]) begin
        fails++;
        $display("FAIL sat4 t=%0t cyc/stall/state act=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 $time, cycS, stallS, stateS, eCycS, eStallS, e.ctl[2:0]);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0; run_req = 0; step_req = 0; halt_req = 0;
    bus.ifid_opcode = 6'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
    bus.idex_memread = 0; bus.idex_rt = 5'd0; bus.pc_src = 0; bus.jump_flag = 0;

    s = nop(); s.rstn = 0;
    repeat (3) apply(s);
    idle(2);

    // Run, then ten free cycles
    s = nop(); s.run = 1; apply(s);
    idle(10);

    // Load-use stall, then a load into r0
    s = nop(); s.mr = 1; s.irt = 5'd5; s.rs = 5'd5; apply(s);
    idle(1);
    s = nop(); s.mr = 1; s.irt = 5'd0; s.rs = 5'd0; apply(s);
    s = nop(); s.mr = 1; s.irt = 5'd7; s.rt = 5'd7; apply(s);
    // Stall condition coinciding with a taken branch
    s = nop(); s.mr = 1; s.irt = 5'd5; s.rs = 5'd5; s.pcs = 1; apply(s);
    s = nop(); s.mr = 1; s.irt = 5'd5; s.rs = 5'd5; s.jmp = 1; apply(s);

    // Pause, then three single steps
    s = nop(); s.halt = 1; apply(s);
    idle(3);
    for (int k = 0; k < 3; k++) begin
      s = nop(); s.step = 1; apply(s);
      s = nop(); s.step = 1; apply(s);
      idle(3);
    end

    // Run with step and run together; HALT behind a jump is dropped
    s = nop(); s.run = 1; s.step = 1; apply(s);
    s = nop(); s.opc = 6'h3f; s.jmp = 1; apply(s);
    s = nop(); s.opc = 6'h3f; s.halt = 1; apply(s);
    for (int k = 0; k < 7; k++) begin
      s = nop(); s.run = k[0]; s.step = k[1]; s.halt = k[2]; apply(s);
    end

    // Reset in the second drain cycle
    s = nop(); s.rstn = 0; apply(s);
    s = nop(); s.run = 1; apply(s);
    s = nop(); s.opc = 6'h3f; apply(s);
    idle(1);
    s = nop(); s.rstn = 0; apply(s);
    idle(2);

    // HALT reached through a single step
    s = nop(); s.step = 1; s.opc = 6'h3f; apply(s);
    idle(2);
    s = nop(); s.step = 1; s.opc = 6'h3f; apply(s);
    idle(6);

    // Saturation of both narrow counters
    s = nop(); s.rstn = 0; apply(s);
    s = nop(); s.run = 1; apply(s);
    for (int k = 0; k < 20; k++) begin
      s = nop(); s.mr = 1; s.irt = 5'd9; s.rt = 5'd9; apply(s);
    end
    idle(5);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      s.rstn = ($urandom_range(0, 199) != 0);
      s.run  = ($urandom_range(0, 9) == 0);
      s.step = ($urandom_range(0, 9) == 0);
      s.halt = ($urandom_range(0, 14) == 0);
      s.opc  = ($urandom_range(0, 39) == 0) ? 6'h3f : 6'($urandom_range(0, 62));
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.mr   = ($urandom_range(0, 1) == 1);
      s.irt  = 5'($urandom_range(0, 3));
      s.pcs  = ($urandom_range(0, 5) == 0);
      s.jmp  = ($urandom_range(0, 7) == 0);
      apply(s);
    end

    @(negedge clk);
    #1;
    tests++;
    if (sbQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
